fmap_stream_reader: RTL
=======================

Name: fmap_stream_reader

Overview:
- Reader/consumer for the packed 4-bit activation store exposed by a pooling or conv layer through its start/done + read_addr/read_data port.
- Triggers the upstream layer, waits for its done pulse, then walks every activation through the nibble-addressed read port.
- Emits activations as a valid/ready stream in either native CHW or flattened HWC order.
- Sits between the last pooling stage and the dense/classifier stage.

Parameters:
- CH, 128, channel count
- H, 4, feature-map height
- W, 4, feature-map width
- ORDER, 0, 0 = CHW (linear address order), 1 = HWC (channel-innermost flatten)
- DW, 4, activation width in bits

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a pass; ignored unless in IDLE
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the final beat is accepted
- up_start  out  1  one-cycle pulse to the upstream layer
- up_done  in  1  one-cycle completion pulse from the upstream layer
- up_read_addr  out  32  activation (nibble) address: ch*H*W + r*W + c
- up_read_data  in  DW  upstream nibble; valid one cycle after up_read_addr, only while the address is still held
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_data  out  DW  activation value
- m_last  out  1  high on the final beat (index CH*H*W-1)

Behaviour:
- Reset values:
  - busy=0, done=0, up_start=0, up_read_addr=0, m_valid=0, m_data=0, m_last=0.
  - State goes to IDLE, counters clear, buffer empties.
  - Reset mid-pass aborts immediately; an up_done arriving later while in IDLE is ignored.
- Upstream read-port timing:
  - The upstream word is registered from the address, but the nibble select decodes the current address.
  - up_read_addr is therefore held for 2 cycles per element: present A in FETCH_ADDR, sample up_read_data in FETCH_CAPTURE with A still driven.
  - Maximum throughput is 1 element per 2 cycles.
- States:
  - IDLE: on start, assert up_start for 1 cycle and busy=1, go to UP_WAIT. A start arriving in the same cycle as reset is lost.
  - UP_WAIT: on up_done, clear ch/r/c and beat counters, go to FETCH_ADDR. There is no timeout.
  - FETCH_ADDR: if buffer occupancy < 2, drive the address for the current (ch,r,c) and go to FETCH_CAPTURE; otherwise stay. up_read_addr holds its value while stalled.
  - FETCH_CAPTURE: push up_read_data into the buffer, tagged last if this is the final element. Advance counters. Go to FETCH_ADDR, or to DRAIN after the final element.
  - DRAIN: wait until the buffer is empty and the last beat has handshaked, then go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Counter order:
  - ORDER=0: c innermost, then r, then ch. Address sequence 0,1,2,…
  - ORDER=1: ch innermost, then c, then r. Address sequence 0, H*W, 2*H*W, …, then 1, …
  - Each counter wraps to 0 at its limit and carries to the next; the final element is ch=CH-1, r=H-1, c=W-1.
- Output buffer (2 entries, first-word fall-through):
  - m_valid = not empty; m_data and m_last come from the head entry.
  - Push and pop in the same cycle are allowed.
  - A push is never issued when occupancy is 2: fetch only starts with occupancy < 2 and at most one fetch is in flight.
  - While m_valid && !m_ready, m_data and m_last stay stable.
- Arithmetic: address computed in 32 bits; the ch*H*W product uses no truncation.
- Beat count per pass is exactly CH*H*W (2048 at defaults); m_last is asserted exactly once.

Decomposition:
- Package fmap_stream_pkg:
  - state enum (IDLE, UP_WAIT, FETCH_ADDR, FETCH_CAPTURE, DRAIN, DONE)
  - ORDER_CHW/ORDER_HWC constants
  - localparam for total element count
- Sub-module fmap_stream_fifo2: 2-entry FWFT buffer of {last, data} with occupancy count. Same clk/reset; push/pop/full/empty ports.

Test Plan:
- Upstream stub model: nibble(addr) = addr[3:0] ^ addr[7:4]; up_done pulses 20 cycles after up_start.
- ORDER=0, m_ready=1 → beats 0..2047 with m_data = nibble(beat); beat 16 = 1, beat 17 = 0; m_last only on beat 2047; done 1–2 cycles later; up_start pulsed exactly once.
- ORDER=1, m_ready=1 → beat k for k<128 reads address 16k: beats 0..3 = 0,1,2,3; beat 128 reads address 1 = 1; m_last on beat 2047 (address 2047, data 0xF^0xF = 0).
- Backpressure:
  - m_ready low for 10 cycles mid-pass → m_data frozen, occupancy saturates at 2, up_read_addr holds.
  - After release → no loss or duplication; beat count is still 2048.
- Upstream read timing: the stub corrupts data if the address changes during its latency cycle → the bench checks each up_read_addr is held ≥ 2 consecutive cycles per element.
- Protocol edges:
  - start asserted while busy → ignored; no second up_start.
  - reset pulsed mid-DRAIN → m_valid=0 and busy=0 the next cycle.
  - A fresh start afterwards → full 2048-beat pass.
- Early up_done: up_done pulsed while in IDLE (before any start) → no fetch begins; a later start still waits for a new up_done.

Source files
------------

// File: rtl/fmap_stream_pkg.sv
// Shared types and constants for the feature-map stream reader.
// Holds FSM states, flatten-order codes, default geometry and sizing helpers.
package fmap_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UP_WAIT,
    FETCH_ADDR,
    FETCH_CAPTURE,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned ORDER_CHW = 0;
  localparam int unsigned ORDER_HWC = 1;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEF_CH = 128;
  localparam int unsigned DEF_H  = 4;
  localparam int unsigned DEF_W  = 4;
  localparam int unsigned DEF_DW = 4;

  function automatic int unsigned elem_count(input int unsigned ch, input int unsigned h,
                                             input int unsigned w);
    return ch * h * w;
  endfunction

  localparam int unsigned TOTAL_ELEMS = elem_count(DEF_CH, DEF_H, DEF_W);

  // Counter width for a modulo-n index, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmap_stream_reader_if.sv
// Upstream activation read port plus the downstream valid/ready stream.
// master = reader side, slave = upstream layer / stream sink side.
interface fmap_stream_reader_if
  import fmap_stream_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
);
  logic              up_start;
  logic              up_done;
  logic [ADDR_W-1:0] up_read_addr;
  logic [DW-1:0]     up_read_data;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic              m_last;

  modport master (
    output up_start, up_read_addr, m_valid, m_data, m_last,
    input  up_done, up_read_data, m_ready
  );

  modport slave (
    input  up_start, up_read_addr, m_valid, m_data, m_last,
    output up_done, up_read_data, m_ready
  );
endinterface

// File: rtl/fmap_stream_fifo2.sv
// Two-entry first-word-fall-through buffer; head is visible while not empty.
// Simultaneous push and pop are allowed; callers never push when full.
module fmap_stream_fifo2 #(
  parameter int unsigned EW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [EW-1:0] push_data,
  input  logic          pop,
  output logic [EW-1:0] head,
  output logic          full,
  output logic          empty
);
  logic [EW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
endmodule

// File: rtl/fmap_stream_reader.sv
// Triggers the upstream layer, then walks its nibble store (CHW or HWC order)
// through a two-cycle address/capture read port into a valid/ready stream.
module fmap_stream_reader
  import fmap_stream_pkg::*;
#(
  parameter int unsigned CH    = DEF_CH,
  parameter int unsigned H     = DEF_H,
  parameter int unsigned W     = DEF_W,
  parameter int unsigned ORDER = ORDER_CHW,
  parameter int unsigned DW    = DEF_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  fmap_stream_reader_if.master bus
);
  localparam int unsigned CW_CH  = cnt_width(CH);
  localparam int unsigned CW_H   = cnt_width(H);
  localparam int unsigned CW_W   = cnt_width(W);
  localparam int unsigned N_ELEM = elem_count(CH, H, W);

  state_t            state, state_nxt;
  logic [CW_CH-1:0]  ch, ch_nxt, ch_adv;
  logic [CW_H-1:0]   r, r_nxt, r_adv;
  logic [CW_W-1:0]   c, c_nxt, c_adv;
  logic [ADDR_W-1:0] addr, addr_nxt, addr_adv;
  logic              busy_nxt, done_nxt, up_start_q, up_start_nxt;
  logic              ch_max, r_max, c_max, is_last_c;
  logic              push, pop, fifo_full, fifo_empty;
  logic [DW:0]       head;

  function automatic logic [ADDR_W-1:0] elem_addr(input logic [CW_CH-1:0] ch_i,
                                                  input logic [CW_H-1:0]  r_i,
                                                  input logic [CW_W-1:0]  c_i);
    return ADDR_W'(ch_i) * ADDR_W'(H * W) + ADDR_W'(r_i) * ADDR_W'(W) + ADDR_W'(c_i);
  endfunction

  // Next (ch,r,c) in the selected flatten order; the address register always
  // tracks the current element so it is already stable in FETCH_ADDR.
  always_comb begin
    ch_max = (ch == CW_CH'(CH - 1));
    r_max  = (r == CW_H'(H - 1));
    c_max  = (c == CW_W'(W - 1));
    ch_adv = ch;
    r_adv  = r;
    c_adv  = c;
    if (ORDER == ORDER_HWC) begin
      ch_adv = ch_max ? '0 : ch + CW_CH'(1);
      if (ch_max) begin
        c_adv = c_max ? '0 : c + CW_W'(1);
        if (c_max) r_adv = r_max ? '0 : r + CW_H'(1);
      end
    end else begin
      c_adv = c_max ? '0 : c + CW_W'(1);
      if (c_max) begin
        r_adv = r_max ? '0 : r + CW_H'(1);
        if (r_max) ch_adv = ch_max ? '0 : ch + CW_CH'(1);
      end
    end
    addr_adv  = elem_addr(ch_adv, r_adv, c_adv);
    is_last_c = (addr == ADDR_W'(N_ELEM - 1));
  end

  always_comb begin
    state_nxt    = state;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    up_start_nxt = 1'b0;
    ch_nxt       = ch;
    r_nxt        = r;
    c_nxt        = c;
    addr_nxt     = addr;
    push         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          up_start_nxt = 1'b1;
          busy_nxt     = 1'b1;
          state_nxt    = UP_WAIT;
        end
      end
      UP_WAIT: begin
        if (bus.up_done) begin
          ch_nxt    = '0;
          r_nxt     = '0;
          c_nxt     = '0;
          addr_nxt  = '0;
          state_nxt = FETCH_ADDR;
        end
      end
      FETCH_ADDR: begin
        if (!fifo_full) state_nxt = FETCH_CAPTURE;
      end
      FETCH_CAPTURE: begin
        push = 1'b1;
        if (is_last_c) begin
          state_nxt = DRAIN;
        end else begin
          ch_nxt    = ch_adv;
          r_nxt     = r_adv;
          c_nxt     = c_adv;
          addr_nxt  = addr_adv;
          state_nxt = FETCH_ADDR;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ch         <= '0;
      r          <= '0;
      c          <= '0;
      addr       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      up_start_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      ch         <= ch_nxt;
      r          <= r_nxt;
      c          <= c_nxt;
      addr       <= addr_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      up_start_q <= up_start_nxt;
    end
  end

  assign pop = !fifo_empty && bus.m_ready;

  fmap_stream_fifo2 #(
    .EW(DW + 1)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data({is_last_c, bus.up_read_data}),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.up_start     = up_start_q;
  assign bus.up_read_addr = addr;
  assign bus.m_valid      = !fifo_empty;
  assign bus.m_data       = head[DW-1:0];
  assign bus.m_last       = head[DW];
endmodule
